// File: rtl/time_set_if.sv
// Front-panel bundle between the board buttons, the time-set controller and
// the counter chain. The slave side is the controller itself.
interface time_set_if;
  logic       SAMPLE_EN;
  logic       BTN_MODE;
  logic       BTN_SEL;
  logic       BTN_INC;
  logic       BASE;
  logic [5:0] SETTIME;
  logic       BAP_BTN3;
  logic       BLINK;

  modport slave (
    input  SAMPLE_EN, BTN_MODE, BTN_SEL, BTN_INC,
    output BASE, SETTIME, BAP_BTN3, BLINK
  );

  modport master (
    output SAMPLE_EN, BTN_MODE, BTN_SEL, BTN_INC,
    input  BASE, SETTIME, BAP_BTN3, BLINK
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-set controller: synchronises and debounces MODE/SEL/INC, runs the RUN/SET
// state machine and drives BASE, one-hot SETTIME, BAP_BTN3 strobes and BLINK.
module time_set_ctrl #(
  parameter int DB_CNT     = 4,
  parameter int REP_DLY    = 500,
  parameter int REP_PER    = 100,
  parameter int TIMEOUT    = 30000,
  parameter int BLINK_HALF = 250
) (
  input  logic        CLK,
  input  logic        RESET,
  time_set_if.slave   bus
);

  localparam int DBW  = $clog2(DB_CNT) + 1;
  localparam int REPM = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int RW   = $clog2(REPM) + 1;
  localparam int TW   = $clog2(TIMEOUT) + 1;
  localparam int BW   = $clog2(BLINK_HALF) + 1;

  localparam logic [DBW-1:0] DB_TOP  = DBW'(DB_CNT - 1);
  localparam logic [RW-1:0]  DLY_TOP = RW'(REP_DLY - 1);
  localparam logic [RW-1:0]  PER_TOP = RW'(REP_PER - 1);
  localparam logic [TW-1:0]  TO_TOP  = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0]  BL_TOP  = BW'(BLINK_HALF - 1);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_SET = 1'b1} state_t;

  // Button index: 0 MODE, 1 SEL, 2 INC
  logic [2:0]     r_sync1;
  logic [2:0]     r_sync2;
  logic [2:0]     r_db;
  logic [2:0]     r_db_d;
  logic [DBW-1:0] r_dbc [0:2];

  state_t         r_state;
  logic           r_base;
  logic [5:0]     r_settime;
  logic           r_bap;
  logic           r_blink;
  logic [TW-1:0]  r_to;
  logic [BW-1:0]  r_blc;
  logic [RW-1:0]  r_hold;
  logic           r_armed;

  logic [2:0]     w_press;
  logic           w_mode_p;
  logic           w_sel_p;
  logic           w_inc_p;
  logic [RW-1:0]  w_hold_top;
  logic           w_rep_fire;
  logic           w_to_fire;

  // Two-flop synchroniser followed by a sample-driven debounce counter per button
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
      r_db    <= 3'b000;
      r_db_d  <= 3'b000;
      for (int i = 0; i < 3; i++) r_dbc[i] <= '0;
    end else begin
      r_sync1 <= {bus.BTN_INC, bus.BTN_SEL, bus.BTN_MODE};
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      if (bus.SAMPLE_EN) begin
        for (int i = 0; i < 3; i++) begin
          if (r_sync2[i] != r_db[i]) begin
            if (r_dbc[i] == DB_TOP) begin
              r_db[i]  <= ~r_db[i];
              r_dbc[i] <= '0;
            end else begin
              r_dbc[i] <= r_dbc[i] + 1'b1;
            end
          end else begin
            r_dbc[i] <= '0;
          end
        end
      end
    end
  end

  // Same-cycle presses resolve MODE > SEL > INC; losers are dropped
  assign w_press    = r_db & ~r_db_d;
  assign w_mode_p   = w_press[0];
  assign w_sel_p    = w_press[1] & ~w_press[0];
  assign w_inc_p    = w_press[2] & ~w_press[1] & ~w_press[0];
  assign w_hold_top = r_armed ? PER_TOP : DLY_TOP;
  assign w_rep_fire = (r_state == ST_SET) && r_db[2] && !w_press[0] && !w_press[1]
                      && bus.SAMPLE_EN && (r_hold == w_hold_top) && !r_bap;
  assign w_to_fire  = (r_state == ST_SET) && bus.SAMPLE_EN && (r_to == TO_TOP)
                      && !(|w_press) && !w_rep_fire;

  // RUN/SET state machine with registered outputs and its timing counters
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= ST_RUN;
      r_base    <= 1'b1;
      r_settime <= 6'b000000;
      r_bap     <= 1'b0;
      r_blink   <= 1'b0;
      r_to      <= '0;
      r_blc     <= '0;
      r_hold    <= '0;
      r_armed   <= 1'b0;
    end else begin
      r_bap <= 1'b0;
      case (r_state)
        ST_RUN: begin
          r_to    <= '0;
          r_blc   <= '0;
          r_hold  <= '0;
          r_armed <= 1'b0;
          if (w_mode_p) begin
            r_state   <= ST_SET;
            r_base    <= 1'b0;
            r_settime <= 6'b100000;
            r_blink   <= 1'b1;
          end else begin
            r_base    <= 1'b1;
            r_settime <= 6'b000000;
            r_blink   <= 1'b0;
          end
        end
        ST_SET: begin
          if (w_mode_p || w_to_fire) begin
            r_state   <= ST_RUN;
            r_base    <= 1'b1;
            r_settime <= 6'b000000;
            r_blink   <= 1'b0;
            r_to      <= '0;
            r_blc     <= '0;
            r_hold    <= '0;
            r_armed   <= 1'b0;
          end else begin
            if ((|w_press) || w_rep_fire) begin
              r_to <= '0;
            end else if (bus.SAMPLE_EN) begin
              r_to <= r_to + 1'b1;
            end
            // Hold counter saturates at its target if a strobe is still in flight
            if (!r_db[2] || w_sel_p) begin
              r_hold  <= '0;
              r_armed <= 1'b0;
            end else if (bus.SAMPLE_EN) begin
              if (r_hold == w_hold_top) begin
                if (!r_bap) begin
                  r_hold  <= '0;
                  r_armed <= 1'b1;
                end
              end else begin
                r_hold <= r_hold + 1'b1;
              end
            end
            if (w_sel_p) begin
              r_settime <= {r_settime[0], r_settime[5:1]};
              r_blink   <= 1'b0;
              r_blc     <= '0;
            end else if (w_inc_p || w_rep_fire) begin
              r_bap   <= 1'b1;
              r_blink <= 1'b0;
              r_blc   <= '0;
            end else if (bus.SAMPLE_EN) begin
              if (r_blc == BL_TOP) begin
                r_blink <= ~r_blink;
                r_blc   <= '0;
              end else begin
                r_blc <= r_blc + 1'b1;
              end
            end
          end
        end
        default: begin
          r_state   <= ST_RUN;
          r_base    <= 1'b1;
          r_settime <= 6'b000000;
          r_blink   <= 1'b0;
          r_to      <= '0;
          r_blc     <= '0;
          r_hold    <= '0;
          r_armed   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.BASE     = r_base;
  assign bus.SETTIME  = r_settime;
  assign bus.BAP_BTN3 = r_bap;
  assign bus.BLINK    = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: debounce glitch rejection, digit cycling,
// auto-repeat, priority, timeout and asynchronous reset.
module tb_time_set_ctrl;
  logic CLK;
  logic RESET;
  time_set_if bus();

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int dbl    = 0;
  logic prev_bap = 1'b0;

  time_set_ctrl #(
    .DB_CNT(2), .REP_DLY(8), .REP_PER(4), .TIMEOUT(40), .BLINK_HALF(3)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SAMPLE_EN high on every second rising edge
  initial begin
    bus.SAMPLE_EN = 1'b0;
    forever begin
      @(negedge CLK);
      bus.SAMPLE_EN = ~bus.SAMPLE_EN;
    end
  end

  // Strobe monitor: pulse count and back-to-back detection
  initial begin
    forever begin
      @(negedge CLK);
      if (bus.BAP_BTN3 === 1'b1) pulses++;
      if (bus.BAP_BTN3 === 1'b1 && prev_bap === 1'b1) dbl++;
      prev_bap = bus.BAP_BTN3;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (2 * n) @(negedge CLK);
  endtask

  task automatic wait_base(input logic val, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.BASE === val) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic sel_step(input logic [5:0] exp, input string tag);
    logic [5:0] prev;
    bit         seen;
    prev = bus.SETTIME;
    seen = 1'b0;
    bus.BTN_SEL = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (bus.SETTIME !== prev) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk(tag, 32'(bus.SETTIME), 32'(exp));
    chk({tag, "_blink"}, 32'(bus.BLINK), 32'd0);
    bus.BTN_SEL = 1'b0;
    ticks(6);
  endtask

  initial begin
    bit ok;
    bus.BTN_MODE = 1'b0;
    bus.BTN_SEL  = 1'b0;
    bus.BTN_INC  = 1'b0;
    RESET = 1'b1;
    #2 RESET = 1'b0;
    #1;
    chk("rst_base", 32'(bus.BASE), 32'd1);
    chk("rst_settime", 32'(bus.SETTIME), 32'd0);
    chk("rst_bap", 32'(bus.BAP_BTN3), 32'd0);
    chk("rst_blink", 32'(bus.BLINK), 32'd0);
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    ticks(2);

    // Glitching MODE must not be accepted
    for (int i = 0; i < 10; i++) begin
      bus.BTN_MODE = (i % 2 == 0) ? 1'b1 : 1'b0;
      ticks(1);
    end
    chk("glitch_base", 32'(bus.BASE), 32'd1);
    chk("glitch_settime", 32'(bus.SETTIME), 32'd0);
    bus.BTN_MODE = 1'b1;
    wait_base(1'b0, 30, ok);
    chk("db_enter_set", 32'(ok), 32'd1);
    chk("db_settime", 32'(bus.SETTIME), 32'h20);
    chk("db_blink", 32'(bus.BLINK), 32'd1);
    bus.BTN_MODE = 1'b0;
    ticks(6);

    // Digit cycling
    pulses = 0;
    sel_step(6'b010000, "sel1");
    sel_step(6'b001000, "sel2");
    sel_step(6'b000100, "sel3");
    sel_step(6'b000010, "sel4");
    sel_step(6'b000001, "sel5");
    sel_step(6'b100000, "sel6");
    chk("sel_no_bap", 32'(pulses), 32'd0);

    // INC held 22 ticks: press pulse plus repeats at hold ticks 8,12,16,20
    pulses = 0;
    dbl    = 0;
    bus.BTN_INC = 1'b1;
    ticks(22);
    bus.BTN_INC = 1'b0;
    ticks(10);
    chk("rep_pulses", 32'(pulses), 32'd5);
    chk("rep_no_double", 32'(dbl), 32'd0);
    chk("rep_still_set", 32'(bus.BASE), 32'd0);
    ticks(4);
    chk("rep_stopped", 32'(pulses), 32'd5);

    // MODE and INC together: MODE wins, INC discarded
    pulses = 0;
    bus.BTN_MODE = 1'b1;
    bus.BTN_INC  = 1'b1;
    ticks(10);
    chk("prio_base", 32'(bus.BASE), 32'd1);
    chk("prio_settime", 32'(bus.SETTIME), 32'd0);
    chk("prio_no_bap", 32'(pulses), 32'd0);
    bus.BTN_MODE = 1'b0;
    bus.BTN_INC  = 1'b0;
    ticks(8);

    // Timeout back to RUN after 40 idle ticks
    bus.BTN_MODE = 1'b1;
    wait_base(1'b0, 30, ok);
    chk("to_enter_set", 32'(ok), 32'd1);
    bus.BTN_MODE = 1'b0;
    ticks(36);
    chk("to_not_yet", 32'(bus.BASE), 32'd0);
    ticks(6);
    chk("to_base", 32'(bus.BASE), 32'd1);
    chk("to_settime", 32'(bus.SETTIME), 32'd0);
    pulses = 0;
    bus.BTN_INC = 1'b1;
    ticks(8);
    bus.BTN_INC = 1'b0;
    ticks(6);
    chk("run_inc_ignored", 32'(pulses), 32'd0);
    chk("run_base", 32'(bus.BASE), 32'd1);

    // Asynchronous reset while in SET, away from a clock edge
    bus.BTN_MODE = 1'b1;
    wait_base(1'b0, 30, ok);
    chk("rst2_enter_set", 32'(ok), 32'd1);
    bus.BTN_MODE = 1'b0;
    ticks(3);
    sel_step(6'b010000, "rst2_sel");
    @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    chk("rst2_base", 32'(bus.BASE), 32'd1);
    chk("rst2_settime", 32'(bus.SETTIME), 32'd0);
    chk("rst2_bap", 32'(bus.BAP_BTN3), 32'd0);
    chk("rst2_blink", 32'(bus.BLINK), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    ticks(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Front-panel time-set controller for the 24-hour clock. Debounces three raw push buttons and runs a RUN/SET mode state machine. It produces the time-set controls consumed by the hour/minute/second counter chain: BASE, a one-hot digit select, and a single-cycle increment strobe BAP_BTN3. It sits between the board buttons and the COUNT24/CNT60 instances.

Parameters:
DB_CNT, 4, consecutive equal SAMPLE_EN samples required to accept a button level change (range 1..15)
REP_DLY, 500, SAMPLE_EN ticks INC must be held before the first auto-repeat strobe
REP_PER, 100, SAMPLE_EN ticks between subsequent auto-repeat strobes
TIMEOUT, 30000, SAMPLE_EN ticks without any button press before SET falls back to RUN
BLINK_HALF, 250, SAMPLE_EN ticks per BLINK half-period

Ports:
CLK  in  1  system clock; all state updates on its rising edge
RESET  in  1  asynchronous, active-low reset
SAMPLE_EN  in  1  one-CLK-wide debounce/timing tick (nominally 1 kHz)
BTN_MODE  in  1  raw button, active-high, asynchronous to CLK
BTN_SEL  in  1  raw button, active-high, asynchronous to CLK
BTN_INC  in  1  raw button, active-high, asynchronous to CLK
BASE  out  1  1 = normal counting (RUN), 0 = time-set mode (SET)
SETTIME  out  6  one-hot digit select; bit 0 sec1, 1 sec10, 2 min1, 3 min10, 4 hour1, 5 hour10
BAP_BTN3  out  1  one-CLK increment strobe for the selected digit
BLINK  out  1  display blink enable for the selected digit

Behaviour:
- Reset (RESET low, asynchronous): state RUN, BASE=1, SETTIME=6'b000000, BAP_BTN3=0, BLINK=0. All debounce levels=0 and all counters=0. Release is sampled on CLK.
- Synchronisation: each button passes through 2 flip-flops before debounce.
- Debounce, per button:
  - The counter advances only on SAMPLE_EN.
  - If the synced level differs from the debounced level, increment the counter; otherwise clear it.
  - When the counter reaches DB_CNT, flip the debounced level and clear the counter.
  - A press event is a 0->1 transition of the debounced level, one CLK wide.
- Latency: a raw change held stable is accepted within 2 + DB_CNT×(SAMPLE_EN period) + 1 CLK.
- RUN state:
  - BASE=1, SETTIME=0, BAP_BTN3=0, BLINK=0.
  - MODE press -> SET with SETTIME=6'b100000. The blink counter and timeout counter clear.
  - SEL and INC presses are ignored.
- SET state, with BASE=0:
  - MODE press -> RUN.
  - SEL press -> SETTIME rotates right (100000 -> 010000 -> ... -> 000001 -> 100000).
  - INC press -> BAP_BTN3=1 for exactly one CLK, in the cycle after the press event.
  - Simultaneous press events in one cycle: priority MODE > SEL > INC. Lower-priority events in that cycle are discarded, not deferred.
- Auto-repeat (SET only):
  - While debounced INC stays 1, a hold counter advances on SAMPLE_EN.
  - At REP_DLY ticks: one extra BAP_BTN3 pulse. Thereafter one pulse every REP_PER ticks.
  - INC release, or any SEL/MODE press, clears the hold counter.
  - BAP_BTN3 is never high for 2 consecutive CLKs.
- Timeout:
  - The counter advances on SAMPLE_EN in SET and clears on any press event (including auto-repeat).
  - On reaching TIMEOUT: -> RUN, identical to a MODE press.
- BLINK: in SET, toggles every BLINK_HALF SAMPLE_EN ticks, starting at 1 on SET entry. It is forced to 0 on SET entry after SEL, on every BAP_BTN3 pulse, and in RUN.
- Counter widths: sized by $clog2 of the parameter + 1. All counters saturate or clear; none wraps silently.
- Reset mid-SET: immediate return to RUN values. Any pending strobe is dropped.
- Exactly one SETTIME bit is high in SET; all are zero in RUN.

Test Plan:
- Bench parameters for all scenarios: DB_CNT=2, REP_DLY=8, REP_PER=4, TIMEOUT=40, BLINK_HALF=3, SAMPLE_EN=1 every 2nd CLK.
- Reset/idle: assert RESET=0 mid-run -> BASE=1, SETTIME=000000, BAP_BTN3=0, BLINK=0 immediately, with no CLK edge required.
- Debounce: BTN_MODE toggles 1/0 on every sample for 10 samples, then holds 1 -> the glitch phase gives no state change. After 2 stable samples, BASE=0 and SETTIME=100000.
- Digit cycling: in SET, press SEL 6 times -> SETTIME steps 010000, 001000, 000100, 000010, 000001, 100000. BAP_BTN3 stays 0 throughout.
- Increment and auto-repeat: in SET, hold INC for 20 ticks -> one pulse at press, then pulses at hold ticks 8, 12, 16 and 20. Every pulse is exactly 1 CLK; release stops the pulses.
- Priority: MODE and INC debounced in the same cycle while in SET -> return to RUN, no BAP_BTN3 pulse.
- Timeout: enter SET and idle 40 ticks -> BASE=1, SETTIME=000000. Pressing INC in RUN afterwards gives no BAP_BTN3 pulse.
